nonce_result_scanner: RTL

//  Sits downstream of the nonce-sweep hasher. After the hasher writes NUM_NONCES
//  H0 words to the output region (one word per nonce, word i = nonce i), this

---
 rtl/nonce_result_scanner.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/nonce_result_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : nonce_result_scanner
//  Purpose  : Reads back the NUM_NONCES hash words written by the nonce-sweep
//             hasher and compares each one (unsigned) against a difficulty
//             target. Reports the first hit, the number of hits, and the
//             minimum hash along with the nonce that produced it.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             start, result_addr,   - scan request (accepted only when done=1),
//             target                  base address of word 0, difficulty target
//             done                  - 1 while idle, 0 while a scan is running
//             found, golden_nonce,  - scan results, held until the next
//             hit_count, min_hash,    accepted start
//             min_nonce
//             mem_clk, mem_we,      - shared memory port (read-only usage,
//             mem_addr,               synchronous read: address registered at
//             mem_read_data           edge e, data captured at edge e+2)
//  Revision : 1.0 - initial release
// ============================================================================
module nonce_result_scanner #(
    parameter int NUM_NONCES = 16,
    parameter int IDX_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      result_addr,
    input  logic [31:0]      target,
    output logic             done,
    output logic             found,
    output logic [IDX_W-1:0] golden_nonce,
    output logic [IDX_W:0]   hit_count,
    output logic [31:0]      min_hash,
    output logic [IDX_W-1:0] min_nonce,
    output logic             mem_clk,
    output logic             mem_we,
    output logic [15:0]      mem_addr,
    input  logic [31:0]      mem_read_data
);

    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NUM_NONCES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_SCAN  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [15:0]      r_mem_addr;
    logic [IDX_W-1:0] r_rd_cnt;     // index of the most recently issued address
    logic [IDX_W-1:0] r_cap_cnt;    // index of the word arriving this cycle
    logic [31:0]      r_tgt;
    logic             r_found;
    logic [IDX_W-1:0] r_golden_nonce;
    logic [IDX_W:0]   r_hit_count;
    logic [31:0]      r_min_hash;
    logic [IDX_W-1:0] r_min_nonce;

    logic             w_hit;
    logic             w_new_min;

    assign w_hit     = (mem_read_data < r_tgt);
    assign w_new_min = (mem_read_data < r_min_hash);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_PRIME;
            ST_PRIME: w_state_nxt = ST_SCAN;
            ST_SCAN:  if (r_cap_cnt == c_LAST) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Address generation and result accumulation
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr     <= 16'h0000;
            r_rd_cnt       <= '0;
            r_cap_cnt      <= '0;
            r_tgt          <= 32'h0000_0000;
            r_found        <= 1'b0;
            r_golden_nonce <= '0;
            r_hit_count    <= '0;
            r_min_hash     <= 32'hFFFF_FFFF;
            r_min_nonce    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mem_addr     <= result_addr;
                        r_rd_cnt       <= '0;
                        r_cap_cnt      <= '0;
                        r_tgt          <= target;
                        r_found        <= 1'b0;
                        r_golden_nonce <= '0;
                        r_hit_count    <= '0;
                        r_min_hash     <= 32'hFFFF_FFFF;
                        r_min_nonce    <= '0;
                    end
                end
                ST_PRIME: begin
                    // With a single nonce there is no second word to fetch.
                    if (r_rd_cnt < c_LAST) begin
                        r_mem_addr <= r_mem_addr + 16'd1;
                        r_rd_cnt   <= r_rd_cnt + 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (r_rd_cnt < c_LAST) begin
                        r_mem_addr <= r_mem_addr + 16'd1;
                        r_rd_cnt   <= r_rd_cnt + 1'b1;
                    end
                    r_cap_cnt <= r_cap_cnt + 1'b1;
                    if (w_hit) begin
                        r_hit_count <= r_hit_count + 1'b1;
                        if (!r_found) begin
                            r_found        <= 1'b1;
                            r_golden_nonce <= r_cap_cnt;
                        end
                    end
                    // Strict compare: an equal later word never displaces
                    // the earlier index.
                    if (w_new_min) begin
                        r_min_hash  <= mem_read_data;
                        r_min_nonce <= r_cap_cnt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign done         = (r_state == ST_IDLE);
    assign found        = r_found;
    assign golden_nonce = r_golden_nonce;
    assign hit_count    = r_hit_count;
    assign min_hash     = r_min_hash;
    assign min_nonce    = r_min_nonce;
    assign mem_clk      = clk;
    assign mem_we       = 1'b0;
    assign mem_addr     = r_mem_addr;

endmodule
`default_nettype wire
